// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake, operands and HI/LO result bundle of muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div_by_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle shift-add multiplier / restoring divider with architectural HI/LO.
// Define MULDIV_DIV_EN to build the divider (ops 2/3); otherwise they act as reserved ops.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MULDIV_DIV_EN
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 neg_lo_q, neg_lo_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  logic                 pend_q, pend_d;
  logic                 pend_dbz_q, pend_dbz_d;
`ifdef MULDIV_DIV_EN
  logic                 is_div_q, is_div_d;
  logic                 neg_hi_q, neg_hi_d;
  logic [WIDTH:0]       div_trial_s;
`endif

  logic                 accept_s;
  logic                 sgn_s;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH-1:0]   step_s;
  logic [2*WIDTH-1:0]   fin_p_s;
  logic [WIDTH-1:0]     fin_hi_s, fin_lo_s;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // Operand conditioning, one iteration step and sign-corrected result
  always_comb begin
    accept_s = bus.start && !busy_q;
    sgn_s    = (bus.op == OP_MULT);
`ifdef MULDIV_DIV_EN
    if (bus.op == OP_DIV) begin
      sgn_s = 1'b1;
    end else begin
      sgn_s = (bus.op == OP_MULT);
    end
`endif
    a_mag_s   = magnitude(bus.a, sgn_s);
    b_mag_s   = magnitude(bus.b, sgn_s);
    mul_sum_s = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    step_s    = {mul_sum_s, p_q[WIDTH-1:1]};
    fin_p_s   = neg_lo_q ? -p_q : p_q;
    fin_hi_s  = fin_p_s[2*WIDTH-1:WIDTH];
    fin_lo_s  = fin_p_s[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    // Restoring step: a borrow out of the trial subtraction keeps the old partial remainder
    div_trial_s = p_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    if (is_div_q) begin
      if (div_trial_s[WIDTH]) begin
        step_s = {p_q[2*WIDTH-2:0], 1'b0};
      end else begin
        step_s = {div_trial_s[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
      end
      fin_lo_s = neg_lo_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
      fin_hi_s = neg_hi_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    end else begin
      step_s = {mul_sum_s, p_q[WIDTH-1:1]};
    end
`endif
  end

  // Next-state and register-update logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    opnd_d     = opnd_q;
    neg_lo_d   = neg_lo_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = pend_q;
    dbz_d      = pend_dbz_q;
    pend_d     = 1'b0;
    pend_dbz_d = 1'b0;
`ifdef MULDIV_DIV_EN
    is_div_d   = is_div_q;
    neg_hi_d   = neg_hi_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (bus.op)
            OP_MULTU, OP_MULT: begin
              state_d  = S_CALC;
              busy_d   = 1'b1;
              cnt_d    = '0;
              opnd_d   = a_mag_s;
              p_d      = {{WIDTH{1'b0}}, b_mag_s};
              neg_lo_d = sgn_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`ifdef MULDIV_DIV_EN
              is_div_d = 1'b0;
`endif
            end
`ifdef MULDIV_DIV_EN
            OP_DIVU, OP_DIV: begin
              if (bus.b == '0) begin
                pend_d     = 1'b1;
                pend_dbz_d = 1'b1;
              end else begin
                state_d  = S_CALC;
                busy_d   = 1'b1;
                cnt_d    = '0;
                opnd_d   = b_mag_s;
                p_d      = {{WIDTH{1'b0}}, a_mag_s};
                neg_lo_d = sgn_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_hi_d = sgn_s && bus.a[WIDTH-1];
                is_div_d = 1'b1;
              end
            end
`endif
            OP_MTHI: begin
              hi_d   = bus.a;
              pend_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = bus.a;
              pend_d = 1'b1;
            end
            default: begin
              pend_d = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        p_d   = step_s;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        hi_d    = fin_hi_s;
        lo_d    = fin_lo_s;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      opnd_q     <= '0;
      neg_lo_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_dbz_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      opnd_q     <= opnd_d;
      neg_lo_q   <= neg_lo_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
      pend_q     <= pend_d;
      pend_dbz_q <= pend_dbz_d;
`ifdef MULDIV_DIV_EN
      is_div_q   <= is_div_d;
      neg_hi_q   <= neg_hi_d;
`endif
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner sequences and random ops vs. an arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int LONG = W + 1;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  logic [W-1:0] mhi, mlo;

  muldiv_unit_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model from the architectural definition using plain wide arithmetic
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] eh, output logic [W-1:0] el,
                       output logic ed, output int lat);
    logic [63:0] p;
    eh = mhi; el = mlo; ed = 1'b0; lat = 1;
    case (op)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; {eh, el} = p; lat = LONG; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); {eh, el} = p; lat = LONG; end
      3'd2: if (DIV_EN) begin
              if (b == 32'd0) ed = 1'b1;
              else begin el = a / b; eh = a % b; lat = LONG; end
            end
      3'd3: if (DIV_EN) begin
              if (b == 32'd0) ed = 1'b1;
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin el = a; eh = 32'd0; lat = LONG; end
              else begin el = $signed(a) / $signed(b); eh = $signed(a) % $signed(b); lat = LONG; end
            end
      3'd4: eh = a;
      3'd5: el = a;
      default: ;
    endcase
  endtask

  // Starts an op at the current negedge and returns at the negedge of its done cycle
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                       input int lat, input int intr, input string nm);
    int cyc;
    logic [W-1:0] wh, wl;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(negedge clk);
    bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom_range(0, 7));
    wh = (lat == 1) ? eh : mhi;
    wl = (lat == 1) ? el : mlo;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc <= lat + 2) begin
      check({nm, "_busy"}, 64'(bus.busy), 64'(lat > 1));
      check({nm, "_hi_hold"}, 64'(bus.hi), 64'(wh));
      check({nm, "_lo_hold"}, 64'(bus.lo), 64'(wl));
      check({nm, "_dbz_idle"}, 64'(bus.div_by_zero), 64'd0);
      if (cyc == intr) begin
        bus.start = 1'b1; bus.op = 3'd5; bus.a = $urandom;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({nm, "_latency"}, 64'(cyc), 64'(lat));
    check({nm, "_done"}, 64'(bus.done), 64'd1);
    check({nm, "_hi"}, 64'(bus.hi), 64'(eh));
    check({nm, "_lo"}, 64'(bus.lo), 64'(el));
    check({nm, "_dbz"}, 64'(bus.div_by_zero), 64'(ed));
    check({nm, "_busy_done"}, 64'(bus.busy), 64'd0);
    mhi = eh; mlo = el;
  endtask

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a, b, eh, el;
    logic         ed, seen;
    int           lat;

    vecs[0]  = '{3'd4, 32'h0000_00AB, 32'h0, 32'h0000_00AB, 32'h0, 1'b0, 1};
    vecs[1]  = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LONG};
    vecs[2]  = '{3'd1, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, LONG};
    vecs[3]  = '{3'd0, 32'hFFFF_FFF9, 32'd6, 32'h0000_0005, 32'hFFFF_FFD6, 1'b0, LONG};
    vecs[4]  = '{3'd3, 32'hFFFF_FFF9, 32'd2, DIV_EN ? 32'hFFFF_FFFF : 32'h5,
                 DIV_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFD6, 1'b0, DIV_EN ? LONG : 1};
    vecs[5]  = '{3'd2, 32'd100, 32'd7, DIV_EN ? 32'd2 : 32'h5,
                 DIV_EN ? 32'd14 : 32'hFFFF_FFD6, 1'b0, DIV_EN ? LONG : 1};
    vecs[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIV_EN ? 32'h0 : 32'h5,
                 DIV_EN ? 32'h8000_0000 : 32'hFFFF_FFD6, 1'b0, DIV_EN ? LONG : 1};
    vecs[7]  = '{3'd4, 32'h0000_1234, 32'h0, 32'h0000_1234,
                 DIV_EN ? 32'h8000_0000 : 32'hFFFF_FFD6, 1'b0, 1};
    vecs[8]  = '{3'd5, 32'h0000_5678, 32'h0, 32'h0000_1234, 32'h0000_5678, 1'b0, 1};
    vecs[9]  = '{3'd2, 32'd5, 32'd0, 32'h0000_1234, 32'h0000_5678, DIV_EN, 1};
    vecs[10] = '{3'd6, 32'd1, 32'd1, 32'h0000_1234, 32'h0000_5678, 1'b0, 1};
    vecs[11] = '{3'd7, 32'd3, 32'd3, 32'h0000_1234, 32'h0000_5678, 1'b0, 1};

    tests = 0; fails = 0; mhi = '0; mlo = '0;
    reset = 1'b0; bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(bus.hi), 64'd0);
    check("reset_lo", 64'(bus.lo), 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_dbz", 64'(bus.div_by_zero), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Back-to-back: each vector is started on the done cycle of the previous one
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
            vecs[i].lat, -1, $sformatf("vec%0d", i));
    end

    a = $urandom; b = $urandom;
    model(3'd1, a, b, eh, el, ed, lat);
    do_op(3'd1, a, b, eh, el, ed, lat, 5, "mult_ignored_start");

    bus.start = 1'b1; bus.op = 3'd1; bus.a = $urandom | 32'h1; bus.b = $urandom | 32'h1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < LONG + 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    mhi = '0; mlo = '0;

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      model(op, a, b, eh, el, ed, lat);
      do_op(op, a, b, eh, el, ed, lat, -1, $sformatf("rand%0d_op%0d", i, op));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Successor to the single-cycle ALU multiply path: adds signed/unsigned multiply, divide, MTHI/MTLO and a start/busy/done handshake.
- Sits beside the ALU in the datapath. Control raises `start` and stalls the PC while `busy` is high.
- The register write-back mux reads `hi` and `lo` directly (MFHI/MFLO).

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO, 6/7 reserved.
- a  input  WIDTH  operand A (rs): multiplicand/dividend, MTHI/MTLO source.
- b  input  WIDTH  operand B (rt): multiplier/divisor.
- busy  output  1  iterating; new start ignored.
- done  output  1  one-cycle pulse: operation complete, hi/lo valid.
- div_by_zero  output  1  one-cycle pulse coincident with done for DIV/DIVU with b=0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM=IDLE, counter=0. Reset mid-operation aborts it; no done is produced.
- FSM states: IDLE, CALC, FINISH.
- Acceptance: start=1 and busy=0 at edge k. Operands and op are latched; later changes to a/b/op have no effect.
- MULT/MULTU:
  - IDLE→CALC at k. busy=1 for cycles k+1..k+WIDTH (one shift-add iteration per cycle).
  - CALC→FINISH after WIDTH iterations. At edge k+WIDTH+1: hi:lo = 2*WIDTH-bit product, done=1 for one cycle, busy=0.
- Signed ops (MULT/DIV) work on magnitudes; the result sign is corrected in FINISH.
- DIV/DIVU:
  - Restoring division, same timing as multiply. lo=quotient, hi=remainder.
  - Quotient truncates toward zero. Remainder takes the dividend's sign.
  - DIV of signed MIN by -1: lo=MIN, hi=0, no flag.
- Divide by zero (b=0): no iteration. done=1 and div_by_zero=1 at k+1; hi/lo unchanged.
- MTHI/MTLO: hi (resp. lo) ← a at edge k. done=1 at k+1, busy never asserted.
- Reserved op: no state change; done=1 at k+1.
- start while busy=1: ignored; no queuing, no error.
- start on the same cycle done=1: accepted (FSM is back in IDLE). Back-to-back throughput is one op per WIDTH+1 cycles.
- hi/lo change only at completion (or MTHI/MTLO), never with intermediate values.

Optional Feature:
- MULDIV_DIV_EN
- Defined: divide datapath and ops 2/3 as specified above.
- Undefined: divider logic omitted. Ops 2/3 behave as reserved: done at k+1, hi/lo unchanged, div_by_zero tied 0.

Test Plan:
- Reset: assert reset=0 mid-MULT (cycle 10) → hi=lo=0, busy=0 immediately; no done pulse afterwards.
- MULTU: a=0xFFFFFFFF, b=0xFFFFFFFF → busy cycles 1..32, done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT: a=-7 (0xFFFFFFF9), b=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6; MULTU on the same operands → hi=0x00000005, lo=0xFFFFFFD6.
- DIV: a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Divide by zero: hi=0x1234, lo=0x5678, DIVU b=0 → done and div_by_zero high at k+1, hi/lo unchanged.
- Handshake: start MTHI a=0xAB → hi=0xAB next edge, done at k+1.
- Start MULT, pulse start with MTLO at cycle 5 → ignored, lo equals the product's low word at cycle 33.
- New start on the done cycle → accepted.
